// File: rtl/pipe_pc_unit_if.sv
// -----------------------------------------------------------------------------
// pipe_pc_unit_if
// Bundles the control and address signals between the pipeline and the
// program-counter unit.
//
// Signals (direction as seen by the PC unit):
//   pc_write          in   1        1 = PC may advance, 0 = stall
//   pc_src            in   3        next-PC source select
//   br_taken          in   1        branch condition (used when pc_src = 001)
//   br_target         in   ADDR_W   branch target address
//   jt                in   ADDR_W-6 jump field
//   jr_target         in   ADDR_W   register-jump target
//   pc                out  ADDR_W   current PC
//   redirect_pending  out  1        a held redirect is waiting
//   flush             out  1        PC was loaded non-sequentially last edge
// With PIPE_PC_RAS_EN defined, the return-stack signals are added:
//   ras_push, ras_pop (in), ras_top (out, ADDR_W), ras_empty (out)
//
// Modports: master = pipeline side (drives requests), slave = PC unit.
// -----------------------------------------------------------------------------
interface pipe_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              pc_write;
  logic [2:0]        pc_src;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-7:0] jt;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] pc;
  logic              redirect_pending;
  logic              flush;
`ifdef PIPE_PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  modport master (
    output pc_write, pc_src, br_taken, br_target, jt, jr_target,
    output ras_push, ras_pop,
    input  pc, redirect_pending, flush, ras_top, ras_empty
  );

  modport slave (
    input  pc_write, pc_src, br_taken, br_target, jt, jr_target,
    input  ras_push, ras_pop,
    output pc, redirect_pending, flush, ras_top, ras_empty
  );
`else
  modport master (
    output pc_write, pc_src, br_taken, br_target, jt, jr_target,
    input  pc, redirect_pending, flush
  );

  modport slave (
    input  pc_write, pc_src, br_taken, br_target, jt, jr_target,
    output pc, redirect_pending, flush
  );
`endif
endinterface

// File: rtl/pipe_pc_unit.sv
// -----------------------------------------------------------------------------
// pipe_pc_unit
// Program-counter unit for the pipelined CPU. Chooses the next PC from the
// sequential, branch, jump, register-jump, illegal-op and exception sources.
// Exceptions act even during a stall; other redirects requested during a
// stall are held (latest wins) and applied when the stall releases. A
// one-cycle flush pulse follows every non-sequential load.
//
// Ports:
//   clk_i    in  1   clock, rising edge
//   reset_i  in  1   asynchronous active-high reset
//   bus      slave modport of pipe_pc_unit_if (see that file for signals)
//
// Optional feature: define PIPE_PC_RAS_EN to add a circular return-address
// stack (RAS_DEPTH entries) driven by ras_push / ras_pop.
//
// Handshake: there is no valid/ready pair; pc_write is the only flow
// control. A request is taken on the rising edge it is presented at, except
// that redirects presented while pc_write=0 are captured and deferred.
// -----------------------------------------------------------------------------
module pipe_pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008,
  parameter int          INC       = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  pipe_pc_unit_if.slave bus
);

  localparam int MSB = ADDR_W - 1;

  localparam logic [ADDR_W-1:0] RESET_V = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ILLOP_V = ILLOP_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] XADR_V  = XADR_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-2:0] INC_V   = (ADDR_W-1)'(INC);

  localparam logic [2:0] SRC_SEQ   = 3'b000;
  localparam logic [2:0] SRC_BR    = 3'b001;
  localparam logic [2:0] SRC_JMP   = 3'b010;
  localparam logic [2:0] SRC_JR    = 3'b011;
  localparam logic [2:0] SRC_ILLOP = 3'b100;
  localparam logic [2:0] SRC_XADR  = 3'b101;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_v_q, pend_v_d;
  logic              flush_q, flush_d;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] redir_tgt;
  logic              is_redir;
  logic              is_exc;
  logic [ADDR_W-1:0] exc_vec;
  logic              ld_jmp;
  logic              ld_jr;

  // The supervisor bit is excluded from the increment so sequential flow
  // can never cross privilege levels.
  assign seq_pc = {pc_q[MSB], pc_q[MSB-1:0] + INC_V};
  assign jmp_pc = {pc_q[MSB:MSB-3], bus.jt, 2'b00};

  assign is_exc  = (bus.pc_src == SRC_ILLOP) || (bus.pc_src == SRC_XADR);
  assign exc_vec = (bus.pc_src == SRC_XADR) ? XADR_V : ILLOP_V;

  always_comb begin
    is_redir  = 1'b0;
    redir_tgt = seq_pc;
    case (bus.pc_src)
      SRC_BR: begin
        is_redir  = bus.br_taken;
        redir_tgt = bus.br_taken ? bus.br_target : seq_pc;
      end
      SRC_JMP: begin
        is_redir  = 1'b1;
        redir_tgt = jmp_pc;
      end
      SRC_JR: begin
        is_redir  = 1'b1;
        redir_tgt = bus.jr_target;
      end
      default: begin
        is_redir  = 1'b0;
        redir_tgt = seq_pc;
      end
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_v_d   = pend_v_q;
    flush_d    = 1'b0;
    ld_jmp     = 1'b0;
    ld_jr      = 1'b0;
    if (is_exc) begin
      // Exceptions win over stalls and discard any held redirect.
      pc_d     = exc_vec;
      pend_v_d = 1'b0;
      flush_d  = 1'b1;
    end else if (bus.pc_write) begin
      if (pend_v_q) begin
        pc_d     = pend_tgt_q;
        pend_v_d = 1'b0;
        flush_d  = 1'b1;
      end else begin
        pc_d    = redir_tgt;
        flush_d = is_redir;
        ld_jmp  = (bus.pc_src == SRC_JMP);
        ld_jr   = (bus.pc_src == SRC_JR);
      end
    end else if (is_redir) begin
      // Target is resolved now, from the stalled pc; a later redirect in
      // the same stall simply overwrites it.
      pend_tgt_d = redir_tgt;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q       <= RESET_V;
      pend_tgt_q <= '0;
      pend_v_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_v_q   <= pend_v_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.redirect_pending = pend_v_q;
  assign bus.flush            = flush_q;

`ifdef PIPE_PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]     sp_q;
  logic [PW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;
  logic [PW-1:0]     sp_inc;

  assign do_push = (ld_jmp || ld_jr) && bus.ras_push;
  // Popping an empty stack is a no-op, so gate it here.
  assign do_pop  = ld_jr && bus.ras_pop && (cnt_q != '0);
  assign sp_inc  = sp_q + 1'b1;

  // sp_q indexes the top entry; the pointer wraps, so a push into a full
  // stack lands on the oldest entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sp_q  <= '1;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
    end else if (do_push && do_pop) begin
      ras_mem_q[sp_q] <= seq_pc;
    end else if (do_push) begin
      sp_q              <= sp_inc;
      ras_mem_q[sp_inc] <= seq_pc;
      if (cnt_q != RAS_FULL) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      sp_q  <= sp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_top   = (cnt_q == '0) ? '0 : ras_mem_q[sp_q];
`else
  // Load-kind decodes only feed the return stack.
  logic unused_ld;
  assign unused_ld = ld_jmp ^ ld_jr;
`endif

endmodule

// File: tb/tb_pipe_pc_unit.sv
module tb_pipe_pc_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_pc_unit_if #(.ADDR_W(W)) bus ();

  pipe_pc_unit #(.ADDR_W(W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  typedef struct {
    logic          w;
    logic [2:0]    src;
    logic          bt;
    logic [W-1:0]  btgt;
    logic [W-7:0]  jt;
    logic [W-1:0]  jr;
    logic [W-1:0]  e_pc;
    logic          e_p;
    logic          e_f;
  } vec_t;

  vec_t vecs[$];
  logic [W+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] src, input logic bt,
                     input logic [W-1:0] btgt, input logic [W-7:0] jt, input logic [W-1:0] jr,
                     input logic [W-1:0] e_pc, input logic e_p, input logic e_f);
    vec_t v;
    v.w = w; v.src = src; v.bt = bt; v.btgt = btgt; v.jt = jt; v.jr = jr;
    v.e_pc = e_pc; v.e_p = e_p; v.e_f = e_f;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic w, input logic [2:0] src, input logic bt,
                       input logic [W-1:0] btgt, input logic [W-7:0] jt, input logic [W-1:0] jr);
    bus.pc_write = w; bus.pc_src = src; bus.br_taken = bt;
    bus.br_target = btgt; bus.jt = jt; bus.jr_target = jr;
  endtask

`ifdef PIPE_PC_RAS_EN
  task automatic ras_step(input logic [2:0] src, input logic [W-7:0] jt, input logic push,
                          input logic pop, input logic [W-1:0] e_top, input logic e_empty,
                          input string name);
    @(negedge clk);
    drive(1'b1, src, 1'b0, '0, jt, 32'h8000_0000);
    bus.ras_push = push; bus.ras_pop = pop;
    @(posedge clk); #1;
    check({name, "_top"}, bus.ras_top, e_top);
    check({name, "_empty"}, {31'b0, bus.ras_empty}, {31'b0, e_empty});
  endtask
`endif

  initial begin
    logic [W+1:0] exp;
    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
`ifdef PIPE_PC_RAS_EN
    bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
`endif

    //   w  src     bt  btgt           jt           jr             exp pc         p  f
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_0004, 0, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_0008, 0, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_000C, 0, 0);
    add(1, 3'b001, 0, 32'h1234_5670, '0,          '0,            32'h8000_0010, 0, 0);
    add(0, 3'b010, 0, '0,            26'h40,      '0,            32'h8000_0010, 1, 0);
    add(0, 3'b000, 0, '0,            '0,          '0,            32'h8000_0010, 1, 0);
    add(0, 3'b000, 0, '0,            '0,          '0,            32'h8000_0010, 1, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_0100, 0, 1);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_0104, 0, 0);
    add(0, 3'b001, 1, 32'h8000_0200, '0,          '0,            32'h8000_0104, 1, 0);
    add(0, 3'b011, 0, '0,            '0,          32'h0040_0000, 32'h8000_0104, 1, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h0040_0000, 0, 1);
    add(1, 3'b011, 0, '0,            '0,          32'h8000_0040, 32'h8000_0040, 0, 1);
    add(1, 3'b010, 0, '0,            26'h20,      '0,            32'h8000_0080, 0, 1);
    add(1, 3'b001, 1, 32'h8000_0300, '0,          '0,            32'h8000_0300, 0, 1);
    add(0, 3'b010, 0, '0,            26'h50,      '0,            32'h8000_0300, 1, 0);
    add(0, 3'b101, 0, '0,            '0,          '0,            32'h8000_0008, 0, 1);
    add(0, 3'b000, 0, '0,            '0,          '0,            32'h8000_0008, 0, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_000C, 0, 0);
    add(0, 3'b100, 0, '0,            '0,          '0,            32'h8000_0004, 0, 1);
    add(1, 3'b110, 0, '0,            '0,          '0,            32'h8000_0008, 0, 0);
    add(1, 3'b111, 0, '0,            '0,          '0,            32'h8000_000C, 0, 0);
    add(0, 3'b100, 0, '0,            '0,          '0,            32'h8000_0004, 0, 1);
    add(0, 3'b101, 0, '0,            '0,          '0,            32'h8000_0008, 0, 1);
    add(1, 3'b011, 0, '0,            '0,          32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 1);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'hFFFF_FFFC, 0, 0);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h8000_0000, 0, 0);
    add(1, 3'b001, 0, 32'h0000_0100, '0,          '0,            32'h8000_0004, 0, 0);
    add(0, 3'b000, 0, '0,            '0,          '0,            32'h8000_0004, 0, 0);
    add(1, 3'b011, 0, '0,            '0,          32'h0000_0010, 32'h0000_0010, 0, 1);
    add(1, 3'b010, 0, '0,            26'h3FF_FFFF, '0,           32'h0FFF_FFFC, 0, 1);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h1000_0000, 0, 0);
    add(1, 3'b011, 0, '0,            '0,          32'h7FFF_FFFC, 32'h7FFF_FFFC, 0, 1);
    add(1, 3'b000, 0, '0,            '0,          '0,            32'h0000_0000, 0, 0);

    #1;
    check("reset_pc", bus.pc, 32'h8000_0000);
    check("reset_pend", {31'b0, bus.redirect_pending}, 32'b0);
    check("reset_flush", {31'b0, bus.flush}, 32'b0);
    #11 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].w, vecs[i].src, vecs[i].bt, vecs[i].btgt, vecs[i].jt, vecs[i].jr);
      exp_q.push_back({vecs[i].e_pc, vecs[i].e_p, vecs[i].e_f});
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      check($sformatf("v%0d_pc", i), bus.pc, exp[W+1:2]);
      check($sformatf("v%0d_pend", i), {31'b0, bus.redirect_pending}, {31'b0, exp[1]});
      check($sformatf("v%0d_flush", i), {31'b0, bus.flush}, {31'b0, exp[0]});
    end

    // Reset asserted mid-cycle while a redirect is held: takes effect at once.
    @(negedge clk);
    drive(1'b0, 3'b010, 1'b0, '0, 26'h40, '0);
    @(posedge clk); #1;
    check("hold_pend", {31'b0, bus.redirect_pending}, 32'b1);
    check("hold_pc", bus.pc, 32'h0000_0000);
    drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", bus.pc, 32'h8000_0000);
    check("async_rst_pend", {31'b0, bus.redirect_pending}, 32'b0);
    check("async_rst_flush", {31'b0, bus.flush}, 32'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'b000, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pc", bus.pc, 32'h8000_000C);
    check("post_rst_flush", {31'b0, bus.flush}, 32'b0);
    @(negedge clk);
    drive(1'b1, 3'b011, 1'b0, '0, '0, 32'h8000_0100);
    @(posedge clk); #1;
    check("flush_pulse_hi", {31'b0, bus.flush}, 32'b1);
    drive(1'b1, 3'b000, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    check("flush_pulse_lo", {31'b0, bus.flush}, 32'b0);

`ifdef PIPE_PC_RAS_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ras_rst_empty", {31'b0, bus.ras_empty}, 32'b1);
    check("ras_rst_top", bus.ras_top, 32'b0);
    @(negedge clk);
    reset = 1'b0;
    ras_step(3'b010, 26'h40,  1, 0, 32'h8000_0004, 0, "push1");
    ras_step(3'b010, 26'h80,  1, 0, 32'h8000_0104, 0, "push2");
    ras_step(3'b010, 26'hC0,  1, 0, 32'h8000_0204, 0, "push3");
    ras_step(3'b010, 26'h100, 1, 0, 32'h8000_0304, 0, "push4");
    ras_step(3'b010, 26'h140, 1, 0, 32'h8000_0404, 0, "push5");
    ras_step(3'b011, '0,      0, 1, 32'h8000_0304, 0, "pop1");
    ras_step(3'b011, '0,      0, 1, 32'h8000_0204, 0, "pop2");
    ras_step(3'b011, '0,      0, 1, 32'h8000_0104, 0, "pop3");
    ras_step(3'b011, '0,      0, 1, 32'h0000_0000, 1, "pop4");
    ras_step(3'b011, '0,      0, 1, 32'h0000_0000, 1, "pop_empty");
    // pc is 0x80000000 after the register jumps; a jr with push+pop on an
    // empty stack acts as a push, and a second replaces the top entry.
    ras_step(3'b011, '0,      1, 1, 32'h8000_0004, 0, "pushpop_empty");
    ras_step(3'b011, '0,      1, 1, 32'h8000_0004, 0, "pushpop_repl");
    ras_step(3'b011, '0,      0, 1, 32'h0000_0000, 1, "pop_last");
    bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_pc_unit.md
Name: pipe_pc_unit

Overview:
- Parametrised program-counter unit for the pipelined CPU; next generation of the fixed 32-bit PC register.
- Selects next PC from: sequential, conditional branch, jump, register jump, illegal-op vector, exception vector.
- Exception redirects override stalls; other redirects issued during a stall are held until the stall releases.
- Emits a one-cycle flush pulse after each non-sequential load.

Parameters:
- ADDR_W, 32, PC width; MSB is the supervisor bit; minimum 8.
- RESET_VEC, 32'h8000_0000, PC value after reset, truncated to ADDR_W.
- ILLOP_VEC, 32'h8000_0004, illegal-op/interrupt vector.
- XADR_VEC, 32'h8000_0008, exception vector.
- INC, 4, sequential increment.
- RAS_DEPTH, 4, return-stack entries (power of 2, 2..16); used only with RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  1 = PC may advance; 0 = stall.
- pc_src  in  3  000 seq, 001 branch, 010 jump, 011 register jump, 100 ILLOP, 101 XADR, 110/111 treated as 000.
- br_taken  in  1  branch condition; sampled only when pc_src=001.
- br_target  in  ADDR_W  branch target address.
- jt  in  ADDR_W-6  jump field.
- jr_target  in  ADDR_W  register-jump target (DatabusA).
- pc  out  ADDR_W  current PC.
- redirect_pending  out  1  a held redirect is waiting.
- flush  out  1  registered pulse: PC was loaded non-sequentially in the previous edge.

Behaviour:
- Reset, asynchronous, takes effect immediately: pc=RESET_VEC, pending register cleared, redirect_pending=0, flush=0. Reset has priority over everything, including mid-stall with a redirect pending.
- Next-value candidates:
  - seq = {pc[MSB], pc[MSB-1:0]+INC}. Low bits wrap modulo 2^(ADDR_W-1); the supervisor bit never changes on increment.
  - branch = br_taken ? br_target : seq. Not-taken counts as sequential.
  - jump = {pc[MSB:MSB-3], jt, 2'b00}.
  - regjump = jr_target, loaded verbatim (can change the supervisor bit).
  - exception = ILLOP_VEC or XADR_VEC.
- "Redirect": taken branch, 010 or 011.
- Priority at each rising edge, highest first:
  1. pc_src 100/101: pc = vector, regardless of pc_write. Clears pending. flush=1 next cycle.
  2. pc_write=1 and pending valid: pc = held target. Clears pending. Current pc_src ignored unless it is case 1. flush=1.
  3. pc_write=1, no pending: pc = candidate for pc_src. flush=1 only if the candidate is a redirect.
  4. pc_write=0 and pc_src is a redirect: target is computed from the current pc and inputs, then stored. redirect_pending=1; pc holds. A later redirect during the same stall overwrites the held target (latest wins).
  5. Otherwise pc holds and flush=0.
- Latency:
  - pc updates one edge after the request.
  - flush is high for exactly one cycle, the cycle after the load.
  - redirect_pending rises the cycle after capture and falls the cycle after release.
- Flush on back-to-back redirects: flush stays high in each cycle that follows a redirect load.

Optional Feature:
- Macro: PIPE_PC_RAS_EN.
- With the macro, added ports:
  - ras_push  in  1
  - ras_pop  in  1
  - ras_top  out  ADDR_W
  - ras_empty  out  1
- Push: on an edge where pc loads a jump or register jump and ras_push=1, push the seq value of the old pc.
- Pop: on an edge where pc loads a register jump and ras_pop=1, pop the top entry.
- Simultaneous push and pop: replace the top entry, count unchanged.
- Overflow: when full, a push overwrites the oldest entry (circular pointer); count saturates at RAS_DEPTH.
- Underflow: a pop when empty does nothing.
- ras_top shows the top entry; it is 0 when empty.
- Reset empties the stack.
- Without the macro: the RAS ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset mid-cycle -> pc=0x80000000 immediately, with no clock edge needed. Release, pc_write=1, src=000, 3 edges -> pc=0x8000000C, flush=0.
- Supervisor wrap: reach pc=0xFFFFFFFC, src=000 -> pc=0x80000000. Branch with br_taken=0 -> pc+4 and flush=0.
- Stall capture: pc=0x80000010, pc_write=0, src=010, jt=0x0000040 -> pc holds and redirect_pending=1. Two stalled cycles with src=000, then pc_write=1 with src=000 -> pc=0x80000100, flush pulse, redirect_pending=0.
- Latest wins: during a stall, taken branch to 0x80000200, then src=011 with jr_target=0x00400000 -> on release pc=0x00400000.
- Exception override: stall with a redirect pending, then src=101 while pc_write=0 -> pc=0x80000008 next edge, pending cleared, flush=1.
- RAS (PIPE_PC_RAS_EN):
  - Five jump+push operations from pc=0x80000000, 0x80000100, 0x80000200, 0x80000300 and 0x80000400 with RAS_DEPTH=4.
  - Expect: ras_top=0x80000404.
  - Then pops: 0x80000304, 0x80000204, 0x80000104, then empty. The first pushed entry is lost.
